// File: rtl/addr_seq_ctrl_pkg.sv
// Shared encodings for the operand-address sequencer: FSM states and the
// code points it drives onto the address block's BaseSel / Baseen inputs.
package addr_seq_ctrl_pkg;

    // FSM state encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LDB1  = 3'd1;
    localparam logic [2:0] S_LDB2  = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // BaseSel codes understood by the address block
    localparam logic [2:0] BASE_RD1  = 3'd0;
    localparam logic [2:0] BASE_RD2  = 3'd1;
    localparam logic [2:0] BASE_FIX0 = 3'd2;
    localparam logic [2:0] BASE_ROM  = 3'd3;
    localparam logic [2:0] BASE_FIX1 = 3'd4;
    localparam logic [2:0] BASE_FIX2 = 3'd5;
    localparam logic [2:0] BASE_FIX3 = 3'd6;
    localparam logic [2:0] BASE_FIX4 = 3'd7;

    // Baseen codes: which read-base register latches the ROM output
    localparam logic [1:0] BEN_NONE = 2'd0;
    localparam logic [1:0] BEN_RD1  = 2'd1;
    localparam logic [1:0] BEN_RD2  = 2'd2;

endpackage

// File: rtl/addr_seq_ctrl.sv
// Operand-address sequencer for multi-word field operations. Loads both
// read bases from the base-pointer ROM, interleaves operand-1/operand-2
// word reads, waits out datapath latency, then issues the result writes.
// All outputs are decoded from registered state only (Moore).
module addr_seq_ctrl
    import addr_seq_ctrl_pkg::*;
#(
    parameter int NWORDS = 9,
    parameter int WT_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] src1_sel,
    input  logic [3:0] src2_sel,
    input  logic [2:0] dst_sel,
    output logic [3:0] ROMBaseSel,
    output logic [2:0] BaseSel,
    output logic       OffsetSel,
    output logic [1:0] Baseen,
    output logic [4:0] RdOffset,
    output logic [5:0] WtOffset,
    output logic       suspend,
    output logic       address_carryin,
    output logic       rd_valid,
    output logic       rd_op,
    output logic       mem_we,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] LAST_WORD = 5'(NWORDS - 1);
    // WAIT counts down to 0, so it is preloaded one short of the latency
    localparam logic [3:0] WAIT_INIT = (WT_LAT == 0) ? 4'd0 : 4'(WT_LAT - 1);

    logic [2:0] state;
    logic [4:0] cnt;
    logic       phase;
    logic [3:0] wcnt;
    logic [3:0] src1_q;
    logic [3:0] src2_q;
    logic [2:0] dst_q;

    // State, counters and captured selectors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            phase  <= 1'b0;
            wcnt   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
        end else if (abort) begin
            // abort beats start in IDLE and ends any run without a done pulse
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src1_q <= src1_sel;
                        src2_q <= src2_sel;
                        dst_q  <= dst_sel;
                        state  <= S_LDB1;
                    end
                end
                S_LDB1: state <= S_LDB2;
                S_LDB2: begin
                    cnt   <= '0;
                    phase <= 1'b0;
                    state <= S_READ;
                end
                S_READ: begin
                    phase <= ~phase;
                    if (phase) begin
                        if (cnt == LAST_WORD) begin
                            cnt <= '0;
                            if (WT_LAT == 0) begin
                                state <= S_WRITE;
                            end else begin
                                wcnt  <= WAIT_INIT;
                                state <= S_WAIT;
                            end
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt == 4'd0) begin
                        cnt   <= '0;
                        state <= S_WRITE;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                S_WRITE: begin
                    if (cnt == LAST_WORD) state <= S_DONE;
                    else                  cnt   <= cnt + 5'd1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decode from state, word counter, phase and captured selectors
    always_comb begin
        ROMBaseSel      = '0;
        BaseSel         = BASE_RD1;
        OffsetSel       = 1'b0;
        Baseen          = BEN_NONE;
        RdOffset        = '0;
        WtOffset        = '0;
        suspend         = (state != S_IDLE);
        address_carryin = 1'b0;
        rd_valid        = 1'b0;
        rd_op           = 1'b0;
        mem_we          = 1'b0;
        busy            = (state != S_IDLE);
        done            = 1'b0;
        case (state)
            S_LDB1: begin
                ROMBaseSel = src1_q;
                Baseen     = BEN_RD1;
            end
            S_LDB2: begin
                ROMBaseSel = src2_q;
                Baseen     = BEN_RD2;
            end
            S_READ: begin
                rd_valid = 1'b1;
                rd_op    = phase;
                BaseSel  = phase ? BASE_RD2 : BASE_RD1;
                RdOffset = cnt;
            end
            S_WRITE: begin
                OffsetSel = 1'b1;
                BaseSel   = dst_q;
                WtOffset  = {1'b0, cnt};
                mem_we    = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Scoreboard bench for addr_seq_ctrl: the driver pushes every expected
// strobe event (Baseen, read, write, done) with its cycle index; monitors
// pop and compare whenever a DUT asserts any strobe.
module tb_addr_seq_ctrl;

    typedef struct packed {
        logic [15:0] cyc;
        logic [1:0]  ben;
        logic [3:0]  rom;
        logic        rdv;
        logic        rop;
        logic [2:0]  bsel;
        logic [4:0]  roff;
        logic        we;
        logic        osel;
        logic [5:0]  woff;
        logic        dn;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, abort = 1'b0, start_b = 1'b0;
    logic [3:0] src1_sel = '0, src2_sel = '0;
    logic [2:0] dst_sel = '0;

    logic [3:0] ROMBaseSel, ROMBaseSel_b;
    logic [2:0] BaseSel, BaseSel_b;
    logic       OffsetSel, OffsetSel_b;
    logic [1:0] Baseen, Baseen_b;
    logic [4:0] RdOffset, RdOffset_b;
    logic [5:0] WtOffset, WtOffset_b;
    logic       suspend, suspend_b, address_carryin, address_carryin_b;
    logic       rd_valid, rd_valid_b, rd_op, rd_op_b, mem_we, mem_we_b;
    logic       busy, busy_b, done, done_b;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int base_a = 0;
    int base_b = 0;
    ev_t qa[$];
    ev_t qb[$];

    addr_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src1_sel(src1_sel), .src2_sel(src2_sel), .dst_sel(dst_sel),
        .ROMBaseSel(ROMBaseSel), .BaseSel(BaseSel), .OffsetSel(OffsetSel),
        .Baseen(Baseen), .RdOffset(RdOffset), .WtOffset(WtOffset),
        .suspend(suspend), .address_carryin(address_carryin),
        .rd_valid(rd_valid), .rd_op(rd_op), .mem_we(mem_we),
        .busy(busy), .done(done)
    );

    addr_seq_ctrl #(.NWORDS(1), .WT_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(1'b0),
        .src1_sel(4'd7), .src2_sel(4'd9), .dst_sel(3'd6),
        .ROMBaseSel(ROMBaseSel_b), .BaseSel(BaseSel_b), .OffsetSel(OffsetSel_b),
        .Baseen(Baseen_b), .RdOffset(RdOffset_b), .WtOffset(WtOffset_b),
        .suspend(suspend_b), .address_carryin(address_carryin_b),
        .rd_valid(rd_valid_b), .rd_op(rd_op_b), .mem_we(mem_we_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fmt(input ev_t e);
        return $sformatf("c%0d ben%0d rom%0d rd%0d op%0d bs%0d ro%0d we%0d os%0d wo%0d dn%0d",
                         e.cyc, e.ben, e.rom, e.rdv, e.rop, e.bsel, e.roff,
                         e.we, e.osel, e.woff, e.dn);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_ev(input string name, input ev_t got, input ev_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got [%s] expected [%s]", name, fmt(got), fmt(exp));
        end
    endtask

    // Build the full expected event list of one run, truncated at maxc
    task automatic push_run(input bit which, input int nw, input int wl,
                            input logic [3:0] s1, input logic [3:0] s2,
                            input logic [2:0] d, input int maxc);
        ev_t e;
        ev_t lst[$];
        e = '0; e.cyc = 16'd1; e.ben = 2'd1; e.rom = s1; lst.push_back(e);
        e = '0; e.cyc = 16'd2; e.ben = 2'd2; e.rom = s2; lst.push_back(e);
        for (int w = 0; w < nw; w++) begin
            for (int p = 0; p < 2; p++) begin
                e = '0; e.cyc = 16'(3 + 2*w + p); e.rdv = 1'b1; e.rop = p[0];
                e.bsel = 3'(p); e.roff = 5'(w); lst.push_back(e);
            end
        end
        for (int w = 0; w < nw; w++) begin
            e = '0; e.cyc = 16'(3 + 2*nw + wl + w); e.we = 1'b1; e.osel = 1'b1;
            e.bsel = d; e.woff = 6'(w); lst.push_back(e);
        end
        e = '0; e.cyc = 16'(3 + 3*nw + wl); e.dn = 1'b1; lst.push_back(e);
        foreach (lst[i]) begin
            if (int'(lst[i].cyc) <= maxc) begin
                if (which) qb.push_back(lst[i]);
                else       qa.push_back(lst[i]);
            end
        end
    endtask

    // Monitor for the default-parameter instance
    always @(negedge clk) begin
        ev_t g;
        chk("own_a", {suspend, address_carryin}, {busy, 1'b0});
        if (Baseen != 2'd0 || rd_valid || mem_we || done) begin
            g = '0;
            g.cyc = 16'(cyc - base_a);
            g.ben = Baseen;
            g.dn  = done;
            if (Baseen != 2'd0) g.rom = ROMBaseSel;
            if (rd_valid || mem_we) begin g.bsel = BaseSel; g.osel = OffsetSel; end
            if (rd_valid) begin g.rdv = 1'b1; g.rop = rd_op; g.roff = RdOffset; end
            if (mem_we)   begin g.we = 1'b1; g.woff = WtOffset; end
            if (qa.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL ev_a: unexpected [%s]", fmt(g));
            end else begin
                chk_ev("ev_a", g, qa.pop_front());
            end
        end
    end

    // Monitor for the NWORDS=1, WT_LAT=0 instance
    always @(negedge clk) begin
        ev_t g;
        chk("own_b", {suspend_b, address_carryin_b}, {busy_b, 1'b0});
        if (Baseen_b != 2'd0 || rd_valid_b || mem_we_b || done_b) begin
            g = '0;
            g.cyc = 16'(cyc - base_b);
            g.ben = Baseen_b;
            g.dn  = done_b;
            if (Baseen_b != 2'd0) g.rom = ROMBaseSel_b;
            if (rd_valid_b || mem_we_b) begin g.bsel = BaseSel_b; g.osel = OffsetSel_b; end
            if (rd_valid_b) begin g.rdv = 1'b1; g.rop = rd_op_b; g.roff = RdOffset_b; end
            if (mem_we_b)   begin g.we = 1'b1; g.woff = WtOffset_b; end
            if (qb.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL ev_b: unexpected [%s]", fmt(g));
            end else begin
                chk_ev("ev_b", g, qb.pop_front());
            end
        end
    end

    task automatic wait_idx(input int k);
        while ((cyc - base_a) < k) @(negedge clk);
    endtask

    task automatic kick(input logic [3:0] s1, input logic [3:0] s2,
                        input logic [2:0] d, input int maxc);
        base_a   = cyc;
        src1_sel = s1; src2_sel = s2; dst_sel = d;
        push_run(1'b0, 9, 4, s1, s2, d, maxc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [63:0] outs_a();
        return 64'({ROMBaseSel, BaseSel, OffsetSel, Baseen, RdOffset, WtOffset,
                    suspend, rd_valid, rd_op, mem_we, busy, done});
    endfunction

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outs_a", outs_a(), 64'd0);
        chk("reset_outs_b", {suspend_b, busy_b, Baseen_b, rd_valid_b, mem_we_b, done_b}, 0);
        rst = 1'b0;

        // Idle: port belongs to the scalar-conversion path
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", {suspend, busy, Baseen, rd_valid, mem_we, done}, 0);
        end

        // Full run on both instances; second start pulse in cycle 10 is ignored
        base_b = cyc;
        push_run(1'b1, 1, 0, 4'd7, 4'd9, 3'd6, 1000);
        start_b = 1'b1;
        kick(4'd3, 4'd5, 3'd2, 1000);
        start_b = 1'b0;
        wait_idx(10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idx(34);
        chk("done_c34", {done, busy}, 2'b11);
        wait_idx(40);
        chk("q_empty_run1", 64'(qa.size()), 0);
        chk("q_empty_b", 64'(qb.size()), 0);

        // abort together with start in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle", busy, 0);
        @(negedge clk);
        chk("abort_start_idle2", busy, 0);

        // abort in cycle 27, mid-WRITE
        kick(4'd1, 4'd14, 3'd4, 27);
        wait_idx(27);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_c28", {mem_we, suspend, busy}, 0);
        wait_idx(40);
        chk("q_empty_abort", 64'(qa.size()), 0);

        // Full run after abort
        kick(4'd15, 4'd0, 3'd7, 1000);
        wait_idx(40);
        chk("q_empty_run3", 64'(qa.size()), 0);

        // Async reset mid-READ, away from any clock edge
        kick(4'd2, 4'd6, 3'd3, 8);
        wait_idx(8);
        #2 rst = 1'b1;
        #1 chk("rst_async_outs", outs_a(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("q_empty_rst", 64'(qa.size()), 0);

        // Normal run after reset
        kick(4'd8, 4'd10, 3'd5, 1000);
        wait_idx(40);
        chk("q_empty_run5", 64'(qa.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/addr_seq_ctrl.md
Name: addr_seq_ctrl

Overview:
Sequencer that owns the operand-address block during a multi-word field operation.
- Loads both read-base registers from the base-pointer ROM.
- Issues interleaved word reads of operand 1 and operand 2, waits out the datapath latency, then issues the result-word writes.
- When idle it releases the memory port to the scalar-conversion path by holding suspend low.

Parameters:
NWORDS, 9, words per field element; legal 1..31 (RdOffset is 5 bits)
WT_LAT, 4, idle cycles between last read and first write; legal 0..15; 0 skips WAIT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request; accepted only in IDLE
abort  in  1  synchronous cancel; highest priority after rst
src1_sel  in  4  ROM base index of operand 1
src2_sel  in  4  ROM base index of operand 2
dst_sel  in  3  BaseSel code for the destination
ROMBaseSel  out  4  to address block
BaseSel  out  3  to address block
OffsetSel  out  1  to address block; 1 selects WtOffset
Baseen  out  2  to address block; 1 loads RdBase1, 2 loads RdBase2
RdOffset  out  5  read word index
WtOffset  out  6  write word index
suspend  out  1  1 = this block owns the address mux
address_carryin  out  1  constant 0 in this revision
rd_valid  out  1  a read address is on the bus this cycle
rd_op  out  1  0 = operand 1 word, 1 = operand 2 word
mem_we  out  1  write strobe aligned with the write address
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - State goes to IDLE.
  - Every output is 0: suspend=0, Baseen=0, BaseSel=0, all offsets 0, mem_we=0, rd_valid=0, done=0, busy=0.
  - Selector capture registers are 0.
- Moore outputs: every output is decoded from the state, word counter and phase registers only. No combinational path from any input to any output.
- States and transitions:
  - IDLE: on start=1, capture src1_sel, src2_sel and dst_sel, then go to LDB1.
  - LDB1 (1 cycle): suspend=1, ROMBaseSel=src1, Baseen=1. Next state LDB2.
  - LDB2 (1 cycle): suspend=1, ROMBaseSel=src2, Baseen=2. Next state READ.
  - READ (2*NWORDS cycles): suspend=1, OffsetSel=0, rd_valid=1.
    - Phase 0: BaseSel=0, rd_op=0.
    - Phase 1: BaseSel=1, rd_op=1.
    - RdOffset=word counter, which increments after phase 1.
    - Read order: op1[0], op2[0], op1[1], op2[1], ...
    - After op2[NWORDS-1], go to WAIT (or WRITE if WT_LAT=0).
  - WAIT (WT_LAT cycles): suspend=1, no strobes.
  - WRITE (NWORDS cycles): suspend=1, OffsetSel=1, BaseSel=dst_sel, WtOffset={1'b0,counter}, mem_we=1. Counter runs 0..NWORDS-1, then go to DONE.
  - DONE (1 cycle): done=1, suspend=1. Next state IDLE.
- Latency: with start sampled at edge 0, done is high in cycle 3+3*NWORDS+WT_LAT. Defaults give cycle 34.
- Base loading: Baseen is held only one cycle per base. RdBase1 is valid in LDB2 and RdBase2 is valid in the first READ cycle, so no bubble is needed.
- start while busy is ignored; no queueing. start and abort together in IDLE: abort wins and start is dropped.
- abort in any non-IDLE state: next cycle is IDLE.
  - No done pulse.
  - mem_we is low from that cycle.
  - A write already issued in the abort cycle stands.
- rst mid-operation: immediate IDLE with all outputs 0. A partial write sequence is not rolled back.
- Counters:
  - Word counter is 5 bits and clears on entry to READ and to WRITE.
  - WAIT counter is 4 bits, loaded with WT_LAT-1 and counting down to 0.
  - NWORDS=1 gives exactly 2 reads and 1 write.
- dst_sel is passed through unchecked. Codes 0/1 write over operand space; that is legal but the caller's responsibility.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, LDB1, LDB2, READ, WAIT, WRITE, DONE
  - BaseSel codes: BASE_RD1=0, BASE_RD2=1, BASE_FIX0=2, BASE_ROM=3, BASE_FIX1..4=4..7
  - Baseen codes: BEN_NONE=0, BEN_RD1=1, BEN_RD2=2
- No sub-module; the counters are small enough to inline. The address block itself is instantiated by the parent, not by this block.

Test Plan:
- Default params: start with src1=3, src2=5, dst=2.
  - Cycle 1: Baseen=1, ROMBaseSel=3. Cycle 2: Baseen=2, ROMBaseSel=5.
  - Cycles 3..20: BaseSel alternates 0/1 and RdOffset steps 0,0,1,1..8,8.
  - Cycles 25..33: mem_we=1, BaseSel=2, WtOffset 0..8.
  - done=1 in cycle 34.
- Idle ownership: no start for 10 cycles -> suspend=0, busy=0, all strobes 0 throughout.
- start pulsed again in cycle 10 of a run -> ignored; the run finishes at cycle 34 and a single done pulse is seen.
- abort in cycle 27 (mid-WRITE) -> cycle 28 is IDLE, mem_we=0, suspend=0, done never asserts. A following start runs a full 34-cycle sequence.
- rst asserted asynchronously mid-READ -> outputs go to 0 without waiting for a clock edge; after release, a start runs normally.
- NWORDS=1, WT_LAT=0 -> 2 reads (cycles 3,4), 1 write (cycle 5), done in cycle 6.
